ce_gen_multi: RTL
=================

Name: ce_gen_multi

Overview:
- Parametrised multi-channel clock-enable generator on clk_sys. Generalises the fixed CPU/PSG/12M/6M divider chain.
- Each channel produces a positive-phase enable (ce_p) and a negative-phase enable (ce_n) from a run-time period value.
- Shiftable channels support a run-time speed shift (turbo ratio). Speed changes are applied only at a bus-idle wrap boundary so that no short or double enable is produced.
- Feeds the CPU, bus, PSG and video enable inputs.

Parameters:
- NCH, 4, number of enable channels.
- DIVW, 6, counter and period width per channel.
- SPDW, 2, width of the speed-shift code (shift range 0..2^SPDW-1).
- SHIFT_MASK, 4'b0001, bit i=1 means channel i is affected by the speed shift.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- period_m1  in  NCH*DIVW  per-channel period minus one; channel i uses bits [i*DIVW +: DIVW].
- spd_req  in  SPDW  requested speed shift.
- bus_idle  in  1  high when no bus cycle is in progress; a shift change may be applied.
- ce_p  out  NCH  per-channel positive-phase enable, one-cycle pulse.
- ce_n  out  NCH  per-channel negative-phase enable, one-cycle pulse.
- spd_cur  out  SPDW  speed shift currently in effect.
- spd_done  out  1  one-cycle pulse when spd_cur changes.

Behaviour:
- Per channel i there are two registers: cnt[i] (DIVW bits) and lim[i] (DIVW bits).
  - eff[i] = period_m1[i] >> spd_cur if SHIFT_MASK[i], else period_m1[i].
  - Logical right shift. A shift amount ≥ DIVW gives 0.
- Counting, each cycle:
  - If cnt[i]==lim[i]: cnt[i] <= 0 and lim[i] <= eff[i]. A new period or shift is taken only at the channel's own wrap.
  - Else: cnt[i] <= cnt[i]+1.
- Outputs are registered:
  - ce_p[i] <= (cnt[i]==0).
  - ce_n[i] <= (lim[i]!=0) && (cnt[i]==(lim[i]+1)>>1).
  - (lim+1) is computed DIVW+1 bits wide, so lim=all-ones does not overflow.
- Period is lim+1 cycles. ce_p and ce_n never assert in the same cycle, except that lim=0 gives ce_p every cycle and ce_n never.
- Speed switch:
  - spd_cur changes only in a cycle where cnt[0]==lim[0] and bus_idle==1 and spd_req!=spd_cur. spd_cur <= spd_req and spd_done pulses in the next cycle.
  - Channel 0 is the master and always takes the new eff at that same wrap.
  - Other shiftable channels adopt the new value at their next wrap.
  - If bus_idle==0 at the master wrap, the switch waits for a later master wrap.
  - If spd_req changes again before it is applied, only the latest value is used.
- Reset (reset_n==0, sampled on the clk_sys edge):
  - cnt=0, lim[i]=period_m1[i] unshifted (spd_cur=0).
  - ce_p=0, ce_n=0, spd_cur=0, spd_done=0.
  - Effective mid-operation: outputs clear on the next edge.
  - First ce_p occurs in the first cycle after reset_n goes high.
- Changing period_m1 mid-period never truncates the current period. The current lim completes first.

Optional Feature:
Macro CE_GEN_RESYNC_EN.
- Defined:
  - Extra input resync (1 bit).
  - resync=1 forces cnt[i]<=0 and lim[i]<=eff[i] for all channels in the same cycle. All ce_p then assert together in the following cycle; used for phase alignment after a model change.
  - resync has priority over the normal wrap and increment.
  - A pending speed switch is not applied on a resync cycle.
- Undefined: port absent; channels keep their free-running phases.

Test Plan:
- Reset, channel 0 period_m1=23, spd_req=0, bus_idle=1 → ce_p[0] at cycles 1, 25, 49…; ce_n[0] at cycles 13, 37…; spd_cur=0.
- Same channel, spd_req=1 mid-period with bus_idle=1 → spd_done pulses 1 cycle after the next wrap. Thereafter ce_p[0] every 12 cycles and ce_n[0] 6 cycles after ce_p. Channel 1 (unshifted, period_m1=55) keeps a 56-cycle period.
- spd_req=1 with bus_idle=0 held for 3 master wraps → spd_cur stays 0 and periods stay 24. bus_idle=1 → switch at the next wrap.
- period_m1=0 → ce_p every cycle, ce_n never. period_m1=63 at spd 0 → period 64, ce_n at cnt=32.
- reset_n low mid-period for one cycle → all outputs 0 next edge. After release ce_p resumes at cycle 1 with spd_cur=0.
- CE_GEN_RESYNC_EN: channels period 24/56 out of phase, pulse resync → next cycle all ce_p=1. resync coincident with a pending switch → switch deferred to a later master wrap.

Source files
------------

// File: rtl/ce_gen_multi.sv
// Multi-channel clock-enable generator with run-time period and speed shift.
// Optional CE_GEN_RESYNC_EN adds a resync input that realigns all channels.
module ce_gen_multi #(
    parameter int              NCH        = 4,
    parameter int              DIVW       = 6,
    parameter int              SPDW       = 2,
    parameter logic [NCH-1:0]  SHIFT_MASK = 4'b0001
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [NCH*DIVW-1:0] period_m1,
    input  logic [SPDW-1:0]     spd_req,
    input  logic                bus_idle,
`ifdef CE_GEN_RESYNC_EN
    input  logic                resync,
`endif
    output logic [NCH-1:0]      ce_p,
    output logic [NCH-1:0]      ce_n,
    output logic [SPDW-1:0]     spd_cur,
    output logic                spd_done
);

    logic [DIVW-1:0] cnt_q [NCH];
    logic [DIVW-1:0] cnt_d [NCH];
    logic [DIVW-1:0] lim_q [NCH];
    logic [DIVW-1:0] lim_d [NCH];
    logic [NCH-1:0]  ce_p_q, ce_p_d;
    logic [NCH-1:0]  ce_n_q, ce_n_d;
    logic [SPDW-1:0] spd_cur_q, spd_cur_d;
    logic            spd_done_q, spd_done_d;
    logic            rs;
    logic            sw;

`ifdef CE_GEN_RESYNC_EN
    assign rs = resync;
`else
    assign rs = 1'b0;
`endif

    // Speed switch at an idle master wrap, then per-channel count/reload and enables
    always_comb begin
        sw = (cnt_q[0] == lim_q[0]) && bus_idle
             && (spd_req != spd_cur_q) && !rs;
        spd_cur_d  = sw ? spd_req : spd_cur_q;
        spd_done_d = sw;
        ce_p_d     = '0;
        ce_n_d     = '0;
        for (int i = 0; i < NCH; i++) begin
            logic [DIVW-1:0] pm;
            logic [DIVW-1:0] eff;
            logic [SPDW-1:0] sh;
            logic [DIVW:0]   half;
            pm   = period_m1[i*DIVW +: DIVW];
            // Master adopts the new shift at the very wrap that applies it
            sh   = (i == 0) ? spd_cur_d : spd_cur_q;
            eff  = SHIFT_MASK[i] ? (pm >> sh) : pm;
            half = ({1'b0, lim_q[i]} + (DIVW+1)'(1)) >> 1;
            ce_p_d[i] = (cnt_q[i] == '0);
            ce_n_d[i] = (lim_q[i] != '0)
                        && ({1'b0, cnt_q[i]} == half);
            if (rs || (cnt_q[i] == lim_q[i])) begin
                cnt_d[i] = '0;
                lim_d[i] = eff;
            end else begin
                cnt_d[i] = cnt_q[i] + DIVW'(1);
                lim_d[i] = lim_q[i];
            end
        end
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                lim_q[i] <= period_m1[i*DIVW +: DIVW];
            end
            ce_p_q     <= '0;
            ce_n_q     <= '0;
            spd_cur_q  <= '0;
            spd_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lim_q      <= lim_d;
            ce_p_q     <= ce_p_d;
            ce_n_q     <= ce_n_d;
            spd_cur_q  <= spd_cur_d;
            spd_done_q <= spd_done_d;
        end
    end

    assign ce_p     = ce_p_q;
    assign ce_n     = ce_n_q;
    assign spd_cur  = spd_cur_q;
    assign spd_done = spd_done_q;

endmodule
